// File: rtl/serial_stuff_tx_pkg.sv
// Shared types and defaults for the bit-stuffing serial link.
// Used by the transmitter and any matching receiver/destuffer.
package serial_stuff_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STUFF = 2'd2,
      DONE  = 2'd3
   } tx_state_t;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_STUFF_RUN = 3;

endpackage

// File: rtl/serial_stuff_tx_if.sv
// Load handshake plus serial line bundle for serial_stuff_tx.
// slave: the transmitter. master: the producer/line observer.
interface serial_stuff_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             x_out;
   logic             x_valid;
   logic             busy;
   logic             frame_done;

   modport slave (
      input  data_in, load_valid,
      output load_ready, x_out, x_valid,
      output busy, frame_done
   );

   modport master (
      output data_in, load_valid,
      input  load_ready, x_out, x_valid,
      input  busy, frame_done
   );
endinterface

// File: rtl/serial_stuff_tx_stuff_run_counter.sv
// Counts consecutive transmitted 1s; hit flags the bit that completes a run.
// Ports: clk, rst, clr (sync clear), en (bit sent), bit_in, hit.
module stuff_run_counter #(
   parameter int STUFF_RUN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic hit
);
   localparam int CW = $clog2(STUFF_RUN + 1);
   localparam logic [CW-1:0] LAST = CW'(STUFF_RUN - 1);

   logic [CW-1:0] count;

   // The bit being sent now is the STUFF_RUN-th 1 in a row.
   assign hit = en & bit_in & (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= bit_in ? count + 1'b1 : '0;
      end
   end
endmodule

// File: rtl/serial_stuff_tx.sv
// MSB-first serializer that inserts a 0 after every STUFF_RUN 1s.
// Ports: clk, rst (async high), bus (load handshake + serial line).
module serial_stuff_tx
   import serial_stuff_tx_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int STUFF_RUN = DEF_STUFF_RUN
) (
   input  logic               clk,
   input  logic               rst,
   serial_stuff_tx_if.slave   bus
);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);

   tx_state_t        state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [BW-1:0]    bcnt, bcnt_n;
   logic             x_q, x_n;
   logic             xv_q, xv_n;
   logic             fd_q, fd_n;
   logic             run_clr, run_en, run_hit;

   stuff_run_counter #(.STUFF_RUN(STUFF_RUN)) u_run (
      .clk    (clk),
      .rst    (rst),
      .clr    (run_clr),
      .en     (run_en),
      .bit_in (x_q),
      .hit    (run_hit)
   );

   assign bus.load_ready = (state == IDLE);
   assign bus.busy       = (state == SHIFT) || (state == STUFF);
   assign bus.x_out      = x_q;
   assign bus.x_valid    = xv_q;
   assign bus.frame_done = fd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         bcnt  <= '0;
         x_q   <= 1'b0;
         xv_q  <= 1'b0;
         fd_q  <= 1'b0;
      end else begin
         state <= state_n;
         sreg  <= sreg_n;
         bcnt  <= bcnt_n;
         x_q   <= x_n;
         xv_q  <= xv_n;
         fd_q  <= fd_n;
      end
   end

   // bcnt counts data bits already placed on the line;
   // sreg holds the not-yet-sent bits, next one at the MSB.
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      bcnt_n  = bcnt;
      x_n     = 1'b0;
      xv_n    = 1'b0;
      fd_n    = 1'b0;
      run_clr = 1'b0;
      run_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.load_valid) begin
               state_n = SHIFT;
               sreg_n  = {bus.data_in[WIDTH-2:0], 1'b0};
               x_n     = bus.data_in[WIDTH-1];
               xv_n    = 1'b1;
               bcnt_n  = BW'(1);
               run_clr = 1'b1;
            end
         end
         SHIFT: begin
            run_en = 1'b1;
            // Stuffing wins over end-of-word so a
            // trailing run still gets its 0.
            if (run_hit) begin
               state_n = STUFF;
               xv_n    = 1'b1;
            end else if (bcnt == LAST_BIT) begin
               state_n = DONE;
               fd_n    = 1'b1;
            end else begin
               x_n    = sreg[WIDTH-1];
               xv_n   = 1'b1;
               sreg_n = {sreg[WIDTH-2:0], 1'b0};
               bcnt_n = bcnt + 1'b1;
            end
         end
         STUFF: begin
            run_clr = 1'b1;
            if (bcnt == LAST_BIT) begin
               state_n = DONE;
               fd_n    = 1'b1;
            end else begin
               state_n = SHIFT;
               x_n     = sreg[WIDTH-1];
               xv_n    = 1'b1;
               sreg_n  = {sreg[WIDTH-2:0], 1'b0};
               bcnt_n  = bcnt + 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            bcnt_n  = '0;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_serial_stuff_tx.sv
// Directed bench for serial_stuff_tx (WIDTH=8, STUFF_RUN=3).
// Table of frames plus reset, back-to-back and ignore sequences.
module tb_serial_stuff_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_stuff_tx_if #(.WIDTH(8)) bus ();

   serial_stuff_tx #(.WIDTH(8), .STUFF_RUN(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0]  data;
      int          n;
      logic [31:0] bits;
      bit          poke;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input logic [7:0] d, input bit poke,
                            output logic [31:0] bits, output int n,
                            output bit first_ok, output bit done_ok,
                            output bit ready_ok);
      bits = '0; n = 0;
      first_ok = 0; done_ok = 0; ready_ok = 0;
      @(negedge clk);
      bus.data_in = d;
      bus.load_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.load_valid = 1'b0;
      bus.data_in = 8'h00;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) first_ok = bus.x_valid && bus.busy;
         if (poke && c == 3) begin
            bus.load_valid = 1'b1;
            bus.data_in = 8'hFF;
         end else if (poke && c == 4) begin
            bus.load_valid = 1'b0;
         end
         if (bus.frame_done) begin
            done_ok = !bus.x_valid && !bus.x_out && !bus.load_ready;
            break;
         end
         if (bus.x_valid) begin
            bits = {bits[30:0], bus.x_out};
            n++;
         end
      end
      @(negedge clk);
      ready_ok = bus.load_ready && !bus.x_valid && !bus.frame_done;
   endtask

   logic [31:0] bits;
   int          n, stray;
   bit          f_ok, d_ok, r_ok;
   logic [19:0] sv, so, sf;

   initial begin
      vecs[0] = '{8'hA5, 8,  32'h0A5, 1'b0};
      vecs[1] = '{8'hFF, 10, 32'h3BB, 1'b0};
      vecs[2] = '{8'h07, 9,  32'h00E, 1'b0};
      vecs[3] = '{8'h70, 9,  32'h0E0, 1'b0};
      vecs[4] = '{8'h00, 8,  32'h000, 1'b0};
      vecs[5] = '{8'hA5, 8,  32'h0A5, 1'b1};

      bus.data_in = 8'h00;
      bus.load_valid = 1'b0;
      #12;
      chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
      chk("rst_x_out", 32'(bus.x_out), 32'd0);
      chk("rst_done", 32'(bus.frame_done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ready", 32'(bus.load_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].data, vecs[i].poke, bits, n, f_ok, d_ok, r_ok);
         chk($sformatf("v%0d_len", i), 32'(n), 32'(vecs[i].n));
         chk($sformatf("v%0d_bits", i), bits, vecs[i].bits);
         chk($sformatf("v%0d_first", i), 32'(f_ok), 32'd1);
         chk($sformatf("v%0d_done", i), 32'(d_ok), 32'd1);
         chk($sformatf("v%0d_ready", i), 32'(r_ok), 32'd1);
         if (vecs[i].poke) begin
            stray = 0;
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               if (bus.x_valid || bus.busy) stray++;
            end
            chk("ignore_no_frame", 32'(stray), 32'd0);
         end
      end

      // Reset in the middle of a 0xFF frame.
      @(negedge clk);
      bus.data_in = 8'hFF;
      bus.load_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.load_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_x_valid", 32'(bus.x_valid), 32'd0);
      chk("mid_rst_x_out", 32'(bus.x_out), 32'd0);
      chk("mid_rst_ready", 32'(bus.load_ready), 32'd1);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.frame_done || bus.x_valid) stray++;
      end
      chk("mid_rst_quiet", 32'(stray), 32'd0);
      run_frame(8'hA5, 1'b0, bits, n, f_ok, d_ok, r_ok);
      chk("post_rst_len", 32'(n), 32'd8);
      chk("post_rst_bits", bits, 32'h0A5);
      chk("post_rst_done", 32'(d_ok), 32'd1);

      // Back-to-back: 0x03 then 0xE0 with load_valid held.
      @(negedge clk);
      bus.data_in = 8'h03;
      bus.load_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.data_in = 8'hE0;
      sv = '0; so = '0; sf = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         sv = {sv[18:0], bus.x_valid};
         so = {so[18:0], bus.x_out};
         sf = {sf[18:0], bus.frame_done};
         if (c == 12) bus.load_valid = 1'b0;
      end
      chk("b2b_valid", 32'(sv), 32'(20'b11111111_00_111111111_0));
      chk("b2b_bits", 32'(so), 32'(20'b00000011_00_111000000_0));
      chk("b2b_done", 32'(sf), 32'(20'b00000000_10_000000000_1));
      @(negedge clk);
      chk("b2b_ready", 32'(bus.load_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_stuff_tx.md
Name: serial_stuff_tx

Overview:
- Serial bit-stream transmitter. Serializes a WIDTH-bit parallel word onto a single-bit line, MSB first, one bit per clock.
- Inserts a stuff 0 after every STUFF_RUN consecutive transmitted 1s.
- Acts as the source end of a single-bit x-line. Downstream serial Mealy detectors that count 1-runs consume its output.
- Word intake uses a valid/ready handshake. A one-cycle frame_done pulse closes each frame.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- STUFF_RUN, 3, number of consecutive 1s after which a 0 is inserted (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to transmit. Sampled only on a load handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  block can accept a word. High only in IDLE.
- x_out  output  1  serial data line. Registered.
- x_valid  output  1  x_out carries a data or stuff bit this cycle. Registered.
- busy  output  1  frame in progress (SHIFT or STUFF).
- frame_done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- Reset (async, rst=1): state=IDLE, x_out=0, x_valid=0, frame_done=0, busy=0, load_ready=1, shift register=0, bit counter=0, ones counter=0.
- All outputs except load_ready/busy are registered. load_ready and busy decode from state only.
- States: IDLE, SHIFT, STUFF, DONE.
- IDLE:
  - x_out=0, x_valid=0.
  - On load_valid && load_ready at edge N: capture data_in, clear ones counter, go to SHIFT.
  - From edge N: x_out=data_in[WIDTH-1], x_valid=1. Latency from handshake edge to first bit is one cycle.
- SHIFT (one data bit per cycle, MSB first):
  - For each transmitted bit, ones counter increments if bit=1 and clears if bit=0.
  - If the bit just transmitted is 1 and the counter reaches STUFF_RUN, go to STUFF on the next edge. Do not advance the data pointer.
  - Else if the bit was the last (WIDTH-th) data bit, go to DONE.
  - Else present the next data bit.
- STUFF:
  - For exactly one cycle, x_out=0 and x_valid=1. Clear ones counter.
  - Then resume SHIFT with the next data bit, or go to DONE if all WIDTH bits are sent.
  - A stuff bit after the final data bit is transmitted.
- DONE:
  - For one cycle, frame_done=1, x_valid=0, x_out=0, load_ready=0.
  - Then go to IDLE.
- Frame length is WIDTH + (number of stuff bits) cycles with x_valid=1.
- load_valid held continuously gives one frame per (frame length + 2) cycles, because DONE and IDLE each take one cycle.
- Ones counter never carries across frames. It is cleared on every accepted load.
- load_valid outside IDLE is ignored and data_in is not sampled.
- Reset asserted mid-frame aborts immediately to the reset values. No frame_done is produced and the partial frame is discarded.
- Ones counter width is $clog2(STUFF_RUN+1). Bit counter width is $clog2(WIDTH+1).

Decomposition:
- Shared package: the state encoding typedef (IDLE, SHIFT, STUFF, DONE, 2 bits) and the default WIDTH/STUFF_RUN constants. A matching receiver/destuffer reuses them.
- One natural sub-module: stuff_run_counter (ones-run counter with clear, increment, and "run reached" flag), parameterized by STUFF_RUN.
- Shift register and FSM stay in the top.

Test Plan:
- Reset mid-frame: load 0xFF, assert rst after the 2nd bit -> x_valid=0, x_out=0, load_ready=1 asynchronously. No frame_done. The next load of 0xA5 transmits cleanly from its MSB.
- Load 0xA5 (no runs of 3) -> x_out sequence 1,0,1,0,0,1,0,1 with x_valid=1 for 8 cycles starting one cycle after the handshake. frame_done pulses the following cycle. load_ready is back to 1 one cycle later.
- Load 0xFF -> 1,1,1,0,1,1,1,0,1,1. That is 10 valid cycles with stuff bits at positions 4 and 8.
- Load 0x07 -> 0,0,0,0,0,1,1,1,0. That is 9 valid cycles with the trailing stuff bit transmitted. frame_done follows that bit.
- Back-to-back: hold load_valid with 0x03 then 0xE0 -> first frame 0,0,0,0,0,0,1,1. Second frame 1,1,1,0,0,0,0,0,0 (stuff after its own first three 1s, no carry from the 0x03 trailing 1s). Exactly 2 idle cycles (DONE, IDLE) between frames.
- load_valid pulsed during SHIFT with a different data_in -> ignored. The current frame bits are unchanged and no second frame starts.
